kernel_onchip_memory_tester: RTL and testbench

//  Avalon-MM initiator driving the single-port kernel on-chip RAM slave (1-cycle read latency).

---
 rtl/kernel_onchip_memory_tester_pkg.sv | 31 +++
 rtl/kernel_onchip_memory_tester_pattern_gen.sv | 41 ++++
 rtl/kernel_onchip_memory_tester.sv | 242 ++++++++++++++++++++++++
 tb/tb_kernel_onchip_memory_tester.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/kernel_onchip_memory_tester_pkg.sv
// Purpose : shared types for the kernel on-chip RAM tester.
//           Command op codes, FSM state encoding and a range-check helper.
// Contents: op_e    - command operation codes
//           state_e - tester FSM states (ST_*)
//           range_ok - true when base+len stays inside the RAM
package kernel_mem_tester_pkg;

  typedef enum logic [1:0] {
    OP_FILL  = 2'd0,
    OP_CHECK = 2'd1,
    OP_SUM   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_FILL  = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Widened to 32 bits so base+len cannot overflow before the compare.
  function automatic logic range_ok(input logic [31:0] base,
                                    input logic [31:0] len,
                                    input logic [31:0] depth);
    return (base + len) <= depth;
  endfunction

endpackage

// File: rtl/kernel_onchip_memory_tester_pattern_gen.sv
// Purpose : pattern accumulator, word i = seed + i*incr (mod 2^DATA_W).
// Ports   : clk   - kernel clock
//           load  - restart at seed and latch incr
//           step  - advance to the next pattern word
//           seed  - pattern word 0
//           incr  - per-word step
//           pat   - current pattern word
// Pure datapath: no reset, the tester loads it before every command.
module kernel_pattern_gen #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] incr,
  output logic [DATA_W-1:0] pat
);

  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] incr_q, incr_d;

  always_comb begin
    pat_d  = pat_q;
    incr_d = incr_q;
    if (load) begin
      pat_d  = seed;
      incr_d = incr;
    end else if (step) begin
      pat_d  = pat_q + incr_q;
    end
  end

  always_ff @(posedge clk) begin
    pat_q  <= pat_d;
    incr_q <= incr_d;
  end

  assign pat = pat_q;

endmodule

// File: rtl/kernel_onchip_memory_tester.sv
// Purpose : Avalon-MM initiator that runs FILL / CHECK / SUM commands over a
//           word range of the single-port kernel on-chip RAM.
// Ports   : clk, reset            - kernel clock, synchronous active-high reset
//           cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//           cmd_op/base/len/seed/incr - command fields
//           abort                 - stop issuing, drain reads, finish aborted
//           busy, done            - in progress / 1-cycle completion pulse
//           cmd_err, aborted      - completion status (cmd_err wins)
//           mismatch_cnt, first_bad_addr, sum - command results
//           mem_*                 - Avalon-MM RAM interface (RD_LAT read latency)
module kernel_onchip_memory_tester
  import kernel_mem_tester_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 20480,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_seed,
  input  logic [DATA_W-1:0]   cmd_incr,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                cmd_err,
  output logic                aborted,
  output logic [ADDR_W:0]     mismatch_cnt,
  output logic [ADDR_W-1:0]   first_bad_addr,
  output logic [DATA_W-1:0]   sum,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int DR_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DR_W-1:0]     drain_q, drain_d;
  logic                err_q, err_d;
  logic                abrt_q, abrt_d;
  logic [ADDR_W:0]     mism_q, mism_d;
  logic [ADDR_W-1:0]   first_bad_q, first_bad_d;
  logic [DATA_W-1:0]   sum_q, sum_d;

  logic [RD_LAT-1:0]   vld_p_q, vld_p_d;
  logic [DATA_W-1:0]   pat_p_q [RD_LAT];
  logic [DATA_W-1:0]   pat_p_d [RD_LAT];
  logic [ADDR_W-1:0]   adr_p_q [RD_LAT];
  logic [ADDR_W-1:0]   adr_p_d [RD_LAT];

  logic                pat_load, pat_step, issue_rd, access;
  logic [DATA_W-1:0]   pat;

  kernel_pattern_gen #(.DATA_W(DATA_W)) u_pat (
    .clk  (clk),
    .load (pat_load),
    .step (pat_step),
    .seed (cmd_seed),
    .incr (cmd_incr),
    .pat  (pat)
  );

  // Issue stage: FSM, address/index counters, result capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    len_d       = len_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    drain_d     = drain_q;
    err_d       = err_q;
    abrt_d      = abrt_q;
    mism_d      = mism_q;
    first_bad_d = first_bad_q;
    sum_d       = sum_q;
    pat_load    = 1'b0;
    pat_step    = 1'b0;
    issue_rd    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d        = op_e'(cmd_op);
          base_d      = cmd_base;
          len_d       = cmd_len;
          addr_d      = cmd_base;
          rem_d       = cmd_len;
          err_d       = 1'b0;
          abrt_d      = 1'b0;
          mism_d      = '0;
          first_bad_d = '0;
          sum_d       = '0;
          pat_load    = 1'b1;
          state_d     = ST_CHK;
        end
      end
      ST_CHK: begin
        if (op_q == OP_RSVD ||
            !range_ok(32'(base_q), 32'(len_q), 32'(DEPTH))) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else if (abort) begin
          abrt_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = (op_q == OP_FILL) ? ST_FILL : ST_READ;
        end
      end
      ST_FILL: begin
        pat_step = 1'b1;
        addr_d   = addr_q + 1'b1;
        rem_d    = rem_q - 1'b1;
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = ST_DONE;
        end else if (rem_q == (ADDR_W+1)'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        issue_rd = 1'b1;
        pat_step = 1'b1;
        addr_d   = addr_q + 1'b1;
        rem_d    = rem_q - 1'b1;
        drain_d  = DR_W'(RD_LAT - 1);
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = ST_DRAIN;
        end else if (rem_q == (ADDR_W+1)'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Reads are already in flight; abort only changes the status here.
        if (abort) abrt_d = 1'b1;
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Readdata returning for a read issued RD_LAT cycles ago.
    if (vld_p_q[RD_LAT-1]) begin
      if (op_q == OP_CHECK && mem_readdata != pat_p_q[RD_LAT-1]) begin
        mism_d = sat_inc(mism_q);
        if (mism_q == '0) first_bad_d = adr_p_q[RD_LAT-1];
      end
      if (op_q == OP_SUM) sum_d = sum_q + mem_readdata;
    end
  end

  // Read-return stages p0..p(RD_LAT-1): expected pattern and address follow the read.
  always_comb begin
    vld_p_d[0] = issue_rd;
    pat_p_d[0] = pat;
    adr_p_d[0] = addr_q;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_p_d[k] = vld_p_q[k-1];
      pat_p_d[k] = pat_p_q[k-1];
      adr_p_d[k] = adr_p_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FILL;
      rem_q       <= '0;
      drain_q     <= '0;
      err_q       <= 1'b0;
      abrt_q      <= 1'b0;
      mism_q      <= '0;
      first_bad_q <= '0;
      sum_q       <= '0;
      vld_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      abrt_q      <= abrt_d;
      mism_q      <= mism_d;
      first_bad_q <= first_bad_d;
      sum_q       <= sum_d;
      vld_p_q     <= vld_p_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    len_q  <= len_d;
    addr_q <= addr_d;
    for (int k = 0; k < RD_LAT; k++) begin
      pat_p_q[k] <= pat_p_d[k];
      adr_p_q[k] <= adr_p_d[k];
    end
  end

  // Output stage: bus signals decoded from registered state.
  assign access         = (state_q == ST_FILL) || (state_q == ST_READ);
  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign cmd_err        = done & err_q;
  assign aborted        = done & abrt_q & ~err_q;
  assign mismatch_cnt   = mism_q;
  assign first_bad_addr = first_bad_q;
  assign sum            = sum_q;
  assign mem_chipselect = access;
  assign mem_write      = (state_q == ST_FILL);
  assign mem_address    = access ? addr_q : '0;
  assign mem_byteenable = access ? '1 : '0;
  assign mem_writedata  = (state_q == ST_FILL) ? pat : '0;
  assign mem_clken      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_kernel_onchip_memory_tester.sv
module tb_kernel_onchip_memory_tester;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 20480;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [ADDR_W:0]   cmd_len = '0;
  logic [DATA_W-1:0] cmd_seed = '0;
  logic [DATA_W-1:0] cmd_incr = '0;
  logic              abort = 1'b0;
  logic              busy, done, cmd_err, aborted;
  logic [ADDR_W:0]   mismatch_cnt;
  logic [ADDR_W-1:0] first_bad_addr;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  bit   [DATA_W-1:0] ram [DEPTH];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [DATA_W-1:0] poke_data = '0;
  logic              cs_clr = 1'b0;
  int                cs_cnt = 0;
  int                be_bad = 0;
  int                n_chk = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  kernel_onchip_memory_tester dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_incr(cmd_incr),
    .abort(abort), .busy(busy), .done(done), .cmd_err(cmd_err), .aborted(aborted),
    .mismatch_cnt(mismatch_cnt), .first_bad_addr(first_bad_addr), .sum(sum),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // RAM model with 1-cycle read latency plus bench-side poke port.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      else           mem_readdata <= ram[mem_address];
    end
    if (cs_clr) cs_cnt <= 0;
    else if (mem_chipselect) cs_cnt <= cs_cnt + 1;
    if (mem_chipselect && mem_byteenable != 4'hF) be_bad <= be_bad + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one command; returns the cycle (accept = 0) in which done was seen, or -1.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] base,
                         input logic [ADDR_W:0] len, input logic [DATA_W-1:0] seed,
                         input logic [DATA_W-1:0] incr, input int abort_cyc,
                         output int dcyc);
    int cyc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    cmd_seed = seed; cmd_incr = incr; cs_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cs_clr = 1'b0;
    cyc = 1; dcyc = -1;
    while (cyc < 400) begin
      abort = (cyc == abort_cyc);
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
  endtask

  initial begin
    int dc;
    bit saw;

    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_outs", {busy, done, cmd_err, aborted, mem_chipselect, mem_write, mem_clken}, 0);
    check("rst_res", {mismatch_cnt, first_bad_addr, sum}, 0);
    reset = 1'b0;

    // 1: FILL 0x10..0x13
    run_cmd(2'd0, 0, 4, 32'h10, 1, 0, dc);
    check("fill_done_cyc", dc, 6);
    check("fill_err", {cmd_err, aborted}, 0);
    check("fill_cs", cs_cnt, 4);
    check("fill_w0", ram[0], 32'h10);
    check("fill_w3", ram[3], 32'h13);
    check("fill_w4", ram[4], 0);

    // 2: CHECK clean, then with word 2 corrupted
    run_cmd(2'd1, 0, 4, 32'h10, 1, 0, dc);
    check("chk_done_cyc", dc, 7);
    check("chk_clean", mismatch_cnt, 0);
    poke(2, 32'hDEAD);
    run_cmd(2'd1, 0, 4, 32'h10, 1, 0, dc);
    check("chk_mism", mismatch_cnt, 1);
    check("chk_first", first_bad_addr, 2);

    // 3: SUM
    poke(2, 32'h12);
    run_cmd(2'd2, 0, 4, 0, 0, 0, dc);
    check("sum_done_cyc", dc, 7);
    check("sum_val", sum, 32'h46);
    check("sum_clears_mism", mismatch_cnt, 0);
    poke(0, 32'hFFFF_FFFF);
    poke(1, 32'hFFFF_FFFF);
    run_cmd(2'd2, 0, 2, 0, 0, 0, dc);
    check("sum_wrap", sum, 32'hFFFF_FFFE);

    // 4: range error, reserved op, zero length
    run_cmd(2'd0, 20478, 3, 0, 1, 0, dc);
    check("err_done_cyc", dc, 2);
    check("err_flag", {cmd_err, aborted}, 2'b10);
    check("err_cs", cs_cnt, 0);
    run_cmd(2'd3, 0, 1, 0, 1, 0, dc);
    check("rsvd_flag", cmd_err, 1);
    check("rsvd_cs", cs_cnt, 0);
    run_cmd(2'd0, 20479, 1, 32'h55, 1, 0, dc);
    check("edge_ok", {cmd_err, cs_cnt[7:0]}, 9'h001);
    check("edge_word", ram[20479], 32'h55);
    run_cmd(2'd0, 5, 0, 0, 1, 0, dc);
    check("len0_done_cyc", dc, 2);
    check("len0_flags", {cmd_err, aborted}, 0);
    check("len0_cs", cs_cnt, 0);

    // 5: CHECK len=100 aborted at cycle 10
    run_cmd(2'd0, 0, 100, 0, 3, 0, dc);
    check("fill100_cyc", dc, 102);
    check("fill100_w99", ram[99], 297);
    poke(5, 32'hBAD);
    poke(8, 32'hBAD);
    poke(50, 32'hBAD);
    run_cmd(2'd1, 0, 100, 0, 3, 10, dc);
    check("abort_done_cyc", dc, 12);
    check("abort_flags", {cmd_err, aborted}, 2'b01);
    check("abort_reads", cs_cnt, 9);
    check("abort_mism", mismatch_cnt, 2);
    check("abort_first", first_bad_addr, 5);

    // 6: reset in cycle 5 of a FILL
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_base = 200; cmd_len = 10;
    cmd_seed = 7; cmd_incr = 1; cs_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cs_clr = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_cs", mem_chipselect, 0);
    check("rstmid_state", {busy, done, cmd_ready}, 3'b001);
    check("rstmid_res", mismatch_cnt, 0);
    reset = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || mem_chipselect) saw = 1'b1;
    end
    check("rstmid_quiet", saw, 0);
    check("rstmid_writes", cs_cnt, 4);
    check("rstmid_w203", ram[203], 10);
    check("rstmid_w204", ram[204], 0);
    run_cmd(2'd0, 300, 1, 32'hABC, 1, 0, dc);
    check("after_rst_cyc", dc, 3);
    check("after_rst_word", ram[300], 32'hABC);

    check("byteenable", be_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
